// File: rtl/mul_pkg.sv
// Shared constants for the RV32M multiply issue stage: funct3 codes, FSM encoding, timeout width.
package mul_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  // Wide enough for any TIMEOUT_CYCLES up to 256.
  localparam int TO_CNT_W = 8;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } mul_op_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Execute / writeback / BoothMul32 signal bundle for mul_issue_ctrl; slave is the controller side.
interface mul_issue_ctrl_if #(
    parameter int TAG_W = 5
) ();

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             mul_start;
    logic [31:0]      mul_x;
    logic [31:0]      mul_y;
    logic [63:0]      mul_z;
    logic             mul_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
               mul_z, mul_valid, rsp_ready,
        input  req_ready, mul_start, mul_x, mul_y, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
               mul_z, mul_valid, rsp_ready,
        output req_ready, mul_start, mul_x, mul_y, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

endinterface

// File: rtl/mul_sign_fix.sv
// Turns the signed 64-bit product into the RV32M result word, correcting for unsigned operands.
module mul_sign_fix
    import mul_pkg::*;
(
    input  logic [63:0] p,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f3,
    output logic [31:0] res
);

    logic [31:0] hi;
    logic [31:0] a_term;
    logic [31:0] b_term;

    // A negative-looking operand that is really unsigned contributes 2^32 * other operand.
    assign hi     = p[63:32];
    assign a_term = b[31] ? a : 32'd0;
    assign b_term = a[31] ? b : 32'd0;

    always_comb begin
        res = p[31:0];
        case (f3)
            F3_MUL:    res = p[31:0];
            F3_MULH:   res = hi;
            F3_MULHSU: res = hi + a_term;
            F3_MULHU:  res = hi + b_term + a_term;
            default:   res = p[31:0];
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing FSM around BoothMul32 for MUL/MULH/MULHSU/MULHU.
// Optional product cache for MULH/MUL fusion: define MUL_PRODUCT_CACHE_EN.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 40
) (
    input logic             clk,
    input logic             rst,
    mul_issue_ctrl_if.slave bus
);

    logic [2:0]          state;
    logic [2:0]          nxt;
    logic [TO_CNT_W-1:0] cnt;
    mul_op_t             op_q;
    logic [31:0]         data_q;
    logic                err_q;
    logic [TAG_W-1:0]    tag_q;
    logic [31:0]         fix_res;
    logic                illegal;
    logic                timeout;
    logic                hit;
    logic [31:0]         hit_res;

    assign illegal = bus.req_funct3[2];
    assign timeout = cnt >= TO_CNT_W'(TIMEOUT_CYCLES - 1);

    mul_sign_fix u_fix (
        .p   (bus.mul_z),
        .a   (op_q.a),
        .b   (op_q.b),
        .f3  (op_q.f3),
        .res (fix_res)
    );

`ifdef MUL_PRODUCT_CACHE_EN
    logic        c_vld;
    logic [63:0] c_p;
    logic [31:0] c_a;
    logic [31:0] c_b;

    // Correction is applied to the cached raw product using the new request's funct3.
    mul_sign_fix u_hit_fix (
        .p   (c_p),
        .a   (bus.req_rs1),
        .b   (bus.req_rs2),
        .f3  (bus.req_funct3),
        .res (hit_res)
    );

    assign hit = c_vld && (c_a == bus.req_rs1) && (c_b == bus.req_rs2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld <= 1'b0;
            c_p   <= '0;
            c_a   <= '0;
            c_b   <= '0;
        end else if (state == S_BUSY && bus.mul_valid && !bus.flush) begin
            c_vld <= 1'b1;
            c_p   <= bus.mul_z;
            c_a   <= op_q.a;
            c_b   <= op_q.b;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (bus.req_valid) nxt = (illegal || hit) ? S_RESP : S_START;
            S_START: nxt = bus.flush ? S_DRAIN : S_BUSY;
            S_BUSY: begin
                // A flush colliding with the product pulse leaves nothing to drain.
                if (bus.flush)                     nxt = bus.mul_valid ? S_IDLE : S_DRAIN;
                else if (bus.mul_valid || timeout) nxt = S_RESP;
            end
            S_DRAIN: if (bus.mul_valid || timeout) nxt = S_IDLE;
            S_RESP:  if (bus.rsp_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            tag_q  <= '0;
        end else begin
            state <= nxt;
            cnt   <= (state == S_BUSY || state == S_DRAIN) ? cnt + 1'b1 : '0;
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    tag_q <= bus.req_tag;
                    err_q <= illegal;
                    // The multiplier operands are left alone unless it is actually started.
                    if (illegal)  data_q <= '0;
                    else if (hit) data_q <= hit_res;
                    else          op_q   <= '{f3: bus.req_funct3, a: bus.req_rs1, b: bus.req_rs2};
                end
                S_BUSY: if (!bus.flush) begin
                    if (bus.mul_valid) begin
                        data_q <= fix_res;
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.mul_start = (state == S_START);
    assign bus.mul_x     = op_q.a;
    assign bus.mul_y     = op_q.b;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural 32-cycle BoothMul32 stub.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    int   en = 0;
    int   acc_e = 0;
    int   starts = 0;
    int   lat;
    int   s0;
    logic stub_en = 1'b1;
    logic stub_busy;
    int   stub_cnt;

`ifdef MUL_PRODUCT_CACHE_EN
    localparam int HIT_LAT = 0;
    localparam int HIT_STARTS = 0;
`else
    localparam int HIT_LAT = 34;
    localparam int HIT_STARTS = 1;
`endif

    mul_issue_ctrl_if #(.TAG_W(5)) bus ();

    mul_issue_ctrl #(.TAG_W(5), .TIMEOUT_CYCLES(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier stub: start sampled at edge 1 -> mul_valid high between edges 33 and 34.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_busy     <= 1'b0;
            stub_cnt      <= 0;
            bus.mul_valid <= 1'b0;
            bus.mul_z     <= '0;
        end else begin
            bus.mul_valid <= 1'b0;
            if (bus.mul_start && stub_en) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 1;
            end else if (stub_busy) begin
                if (stub_cnt == 32) begin
                    bus.mul_valid <= 1'b1;
                    bus.mul_z     <= $signed({{32{bus.mul_x[31]}}, bus.mul_x})
                                   * $signed({{32{bus.mul_y[31]}}, bus.mul_y});
                    stub_busy     <= 1'b0;
                end
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    always @(posedge clk) if (bus.mul_start) starts++;

    task automatic tick();
        @(posedge clk);
        #1;
        en++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_tag    = tag;
        tick();
        acc_e         = en;
        bus.req_valid = 1'b0;
    endtask

    // lat = edges after the accept edge at which rsp_valid is first seen high.
    task automatic wait_rsp(output int l);
        int n = 0;
        while (!bus.rsp_valid && n < 80) begin
            tick();
            n++;
        end
        l = en - acc_e;
        if (!bus.rsp_valid) chk("rsp_timeout_bound", 64'(bus.rsp_valid), 64'd1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_tag    = '0;
        bus.flush      = 1'b0;
        bus.rsp_ready  = 1'b1;
        #12;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("rst_mul_xy",    {bus.mul_x, bus.mul_y}, 64'd0);
        chk("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        chk("rst_rsp_tag",   64'(bus.rsp_tag),   64'd0);
        rst = 1'b1;
        tick();

        // 1. MUL 7 x -3
        do_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        chk("t1_start", 64'(bus.mul_start), 64'd1);
        tick();
        chk("t1_start_1cyc", 64'(bus.mul_start), 64'd0);
        wait_rsp(lat);
        chk("t1_lat",  64'(lat), 64'd34);
        chk("t1_data", 64'(bus.rsp_data), 64'hFFFF_FFEB);
        chk("t1_tag",  64'(bus.rsp_tag), 64'd5);
        chk("t1_err",  64'(bus.rsp_err), 64'd0);
        chk("t1_xy_held", {bus.mul_x, bus.mul_y}, {32'd7, 32'hFFFF_FFFD});
        tick();
        chk("t1_done", {63'd0, bus.rsp_valid} | {62'd0, bus.req_ready, 1'b0}, 64'd2);

        // 2. MULHU / MULH on all-ones; MULH on most-negative squared
        do_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        wait_rsp(lat);
        chk("t2_mulhu", 64'(bus.rsp_data), 64'hFFFF_FFFE);
        tick();
        do_op(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        wait_rsp(lat);
        chk("t2_mulh_lat", 64'(lat), 64'(HIT_LAT));
        chk("t2_mulh", 64'(bus.rsp_data), 64'h0);
        tick();
        do_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd8);
        wait_rsp(lat);
        chk("t2_mulh_min", 64'(bus.rsp_data), 64'h4000_0000);
        tick();

        // 3. MULHSU -1 x 0x80000000, then illegal funct3
        do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd10);
        wait_rsp(lat);
        chk("t3_mulhsu", 64'(bus.rsp_data), 64'hFFFF_FFFF);
        tick();
        s0 = starts;
        do_op(3'b100, 32'd1, 32'd1, 5'd9);
        chk("t3_ill_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t3_ill_err",   64'(bus.rsp_err), 64'd1);
        chk("t3_ill_data",  64'(bus.rsp_data), 64'd0);
        chk("t3_ill_tag",   64'(bus.rsp_tag), 64'd9);
        tick();
        chk("t3_ill_1cyc",  64'(bus.rsp_valid), 64'd0);
        chk("t3_ill_nostart", 64'(starts - s0), 64'd0);

        // 4. flush in BUSY, then MUL 2 x 3
        do_op(F3_MUL, 32'd5, 32'd6, 5'd3);
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        s0 = 0;
        while (!bus.req_ready && en - acc_e < 80) begin
            if (bus.rsp_valid) s0 = 1;
            tick();
        end
        chk("t4_no_rsp",   64'(s0), 64'd0);
        chk("t4_ready_at", 64'(en - acc_e), 64'd34);
        do_op(F3_MUL, 32'd2, 32'd3, 5'd4);
        wait_rsp(lat);
        chk("t4_mul2x3", 64'(bus.rsp_data), 64'd6);
        tick();

        // 5a. writeback stall: response held stable
        bus.rsp_ready = 1'b0;
        do_op(F3_MULH, 32'h0001_0000, 32'h0003_0003, 5'd12);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_tag, bus.rsp_data},
                {1'b1, 1'b0, 5'd12, 32'h0000_0003});
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("t5_release", 64'(bus.rsp_valid), 64'd0);

        // 5b. flush coinciding with the single mul_valid pulse
        do_op(F3_MUL, 32'd11, 32'd13, 5'd1);
        repeat (33) tick();
        chk("t5_mv_pulse", 64'(bus.mul_valid), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t5_flush_idle", {bus.rsp_valid, bus.req_ready}, 64'b01);
        repeat (3) tick();
        chk("t5_flush_norsp", 64'(bus.rsp_valid), 64'd0);

        // 6a. multiplier never answers
        stub_en = 1'b0;
        do_op(F3_MUL, 32'd17, 32'd19, 5'd2);
        wait_rsp(lat);
        chk("t6_to_lat",  64'(lat), 64'd41);
        chk("t6_to_err",  64'(bus.rsp_err), 64'd1);
        chk("t6_to_data", 64'(bus.rsp_data), 64'd0);
        tick();
        stub_en = 1'b1;

        // asynchronous reset mid-operation
        do_op(F3_MUL, 32'd23, 32'd29, 5'd11);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid", {bus.req_ready, bus.mul_start, bus.rsp_valid, bus.mul_x}, {3'b100, 32'd0});
        tick();
        rst = 1'b1;
        tick();

        // 6b. MULH then MUL/MULHU on the same operands (cache hit when enabled)
        do_op(F3_MULH, 32'hFFFF_FFFE, 32'd3, 5'd13);
        wait_rsp(lat);
        chk("t6_mulh_lat", 64'(lat), 64'd34);
        chk("t6_mulh", 64'(bus.rsp_data), 64'hFFFF_FFFF);
        tick();
        s0 = starts;
        do_op(F3_MUL, 32'hFFFF_FFFE, 32'd3, 5'd14);
        wait_rsp(lat);
        chk("t6_mul_lat",    64'(lat), 64'(HIT_LAT));
        chk("t6_mul",        64'(bus.rsp_data), 64'hFFFF_FFFA);
        chk("t6_mul_tag",    64'(bus.rsp_tag), 64'd14);
        chk("t6_mul_starts", 64'(starts - s0), 64'(HIT_STARTS));
        tick();
        do_op(F3_MULHU, 32'hFFFF_FFFE, 32'd3, 5'd15);
        wait_rsp(lat);
        chk("t6_mulhu", 64'(bus.rsp_data), 64'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
